// File: rtl/alu_addr_sequencer_pkg.sv
// rtl/alu_addr_sequencer_pkg.sv - shared CPU types for the address sequencer and ALU controls
package alu_addr_sequencer_pkg;

  typedef enum logic {
    ASEQ_INDEX  = 1'b0,
    ASEQ_BRANCH = 1'b1
  } aseq_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } aseq_state_t;

  typedef enum logic [2:0] {
    ALUOP_HOLD = 3'd0,
    ALUOP_ADD  = 3'd1,
    ALUOP_SUB  = 3'd2,
    ALUOP_AND  = 3'd3,
    ALUOP_OR   = 3'd4,
    ALUOP_XOR  = 3'd5
  } ctrl_alu_op_t;

  // High-byte addend; inverted to 0xFF when a negative displacement needs sign extension.
  localparam logic [7:0] ASEQ_HI_ADDEND = 8'h00;

endpackage

// File: rtl/alu_addr_sequencer_if.sv
// rtl/alu_addr_sequencer_if.sv - controller request and shared-ALU signals of the address sequencer
interface alu_addr_sequencer_if;
  import alu_addr_sequencer_pkg::*;

  logic         start;
  logic         ready;
  aseq_mode_t   mode;
  logic         force_hi;
  logic [15:0]  base;
  logic [7:0]   offset;
  logic         flush;
  logic         alu_req;
  logic         alu_gnt;
  ctrl_alu_op_t alu_op;
  logic [7:0]   alu_src1;
  logic [7:0]   alu_src2;
  logic         alu_src2_inv;
  logic         alu_c_in;
  logic [7:0]   alu_out;
  logic         alu_c_out;
  logic         done;
  logic [15:0]  result;
  logic         page_cross;

  modport master (
    output start, mode, force_hi, base, offset, flush, alu_gnt, alu_out, alu_c_out,
    input  ready, alu_req, alu_op, alu_src1, alu_src2, alu_src2_inv, alu_c_in,
           done, result, page_cross
  );

  modport slave (
    input  start, mode, force_hi, base, offset, flush, alu_gnt, alu_out, alu_c_out,
    output ready, alu_req, alu_op, alu_src1, alu_src2, alu_src2_inv, alu_c_in,
           done, result, page_cross
  );
endinterface

// File: rtl/alu_addr_sequencer.sv
// rtl/alu_addr_sequencer.sv - one/two-cycle 16-bit effective address add on the shared 8-bit ALU
module alu_addr_sequencer
  import alu_addr_sequencer_pkg::*;
#(
  parameter bit SKIP_NOCROSS = 1'b1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  alu_addr_sequencer_if.slave  bus
);

  aseq_state_t  r_state;
  aseq_mode_t   r_mode;
  logic         r_force_hi;
  logic [15:0]  r_base;
  logic [7:0]   r_offset;
  logic         r_c_lo;
  logic [15:0]  r_result;
  logic         r_page_cross;

  aseq_state_t  w_next_state;
  logic         w_adv;
  logic         w_cross;
  logic         w_skip_hi;

  // A cross is detected from carries alone: a negative displacement borrows when carry=0.
  assign w_adv     = bus.alu_req & bus.alu_gnt;
  assign w_cross   = (r_mode == ASEQ_INDEX) ? bus.alu_c_out : (bus.alu_c_out ^ r_offset[7]);
  assign w_skip_hi = !w_cross && !r_force_hi && SKIP_NOCROSS;

  always_comb begin
    w_next_state = r_state;
    if (bus.flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start) w_next_state = LO;
        LO:      if (w_adv) w_next_state = w_skip_hi ? DONE : HI;
        HI:      if (w_adv) w_next_state = DONE;
        DONE:    w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_mode       <= ASEQ_INDEX;
      r_force_hi   <= 1'b0;
      r_base       <= 16'h0000;
      r_offset     <= 8'h00;
      r_c_lo       <= 1'b0;
      r_result     <= 16'h0000;
      r_page_cross <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (!bus.flush) begin
        case (r_state)
          IDLE: if (bus.start) begin
            r_base     <= bus.base;
            r_offset   <= bus.offset;
            r_mode     <= bus.mode;
            r_force_hi <= bus.force_hi;
          end
          LO: if (w_adv) begin
            r_result[7:0] <= bus.alu_out;
            r_c_lo        <= bus.alu_c_out;
            r_page_cross  <= w_cross;
            if (w_skip_hi) r_result[15:8] <= r_base[15:8];
          end
          HI: if (w_adv) r_result[15:8] <= bus.alu_out;
          default: ;
        endcase
      end
    end
  end

  assign bus.ready        = (r_state == IDLE);
  assign bus.alu_req      = (r_state == LO) || (r_state == HI);
  assign bus.alu_op       = bus.alu_req ? ALUOP_ADD : ALUOP_HOLD;
  assign bus.alu_src1     = (r_state == LO) ? r_base[7:0] :
                            (r_state == HI) ? r_base[15:8] : 8'h00;
  assign bus.alu_src2     = (r_state == LO) ? r_offset :
                            (r_state == HI) ? ASEQ_HI_ADDEND : 8'h00;
  assign bus.alu_src2_inv = (r_state == HI) && (r_mode == ASEQ_BRANCH) && r_offset[7];
  assign bus.alu_c_in     = (r_state == HI) ? r_c_lo : 1'b0;
  assign bus.done         = (r_state == DONE);
  assign bus.result       = r_result;
  assign bus.page_cross   = r_page_cross;

endmodule

// File: tb/tb_alu_addr_sequencer.sv
// tb/tb_alu_addr_sequencer.sv - scoreboard bench for alu_addr_sequencer with a behavioural 8-bit ALU
module tb_alu_addr_sequencer;
  import alu_addr_sequencer_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        pc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  alu_addr_sequencer_if bus();

  alu_addr_sequencer #(.SKIP_NOCROSS(1'b1)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU: src1 + (optionally inverted) src2 + carry in.
  logic [7:0] alu_b;
  logic [8:0] alu_sum;
  assign alu_b   = bus.alu_src2_inv ? ~bus.alu_src2 : bus.alu_src2;
  assign alu_sum = {1'b0, bus.alu_src1} + {1'b0, alu_b} + {8'h00, bus.alu_c_in};
  assign bus.alu_out   = alu_sum[7:0];
  assign bus.alu_c_out = alu_sum[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    else passed++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (bus.ready !== 1'b1) $display("FAIL wait_ready: ready=%b after %0d cycles", bus.ready, n);
    else passed++;
  endtask

  task automatic run_op(input string name, input aseq_mode_t m, input logic fh,
                        input logic [15:0] b, input logic [7:0] o, input int stall);
    exp_t e;
    exp_t got;
    logic [15:0] sext;
    logic        hi;
    logic        exp_cin;
    logic        exp_inv;
    logic [8:0]  lo_sum;
    int          n;
    sext    = (m == ASEQ_BRANCH) ? {{8{o[7]}}, o} : {8'h00, o};
    e.res   = b + sext;
    e.pc    = (e.res[15:8] != b[15:8]);
    hi      = e.pc || fh;
    e.lat   = (hi ? 3 : 2) + stall;
    lo_sum  = {1'b0, b[7:0]} + {1'b0, o};
    exp_cin = lo_sum[8];
    exp_inv = (m == ASEQ_BRANCH) && o[7];
    wait_ready();
    sb.push_back(e);
    @(negedge clk);
    bus.mode = m; bus.force_hi = fh; bus.base = b; bus.offset = o;
    bus.start = 1'b1; bus.alu_gnt = (stall == 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      if (n <= stall) begin
        chk({name, "_stall_req"}, {31'd0, bus.alu_req}, 32'd1);
        chk({name, "_stall_src1"}, {24'd0, bus.alu_src1}, {24'd0, b[7:0]});
        bus.start = 1'b1;
        bus.base  = 16'hDEAD;
      end else begin
        bus.start   = 1'b0;
        bus.alu_gnt = 1'b1;
      end
      if (hi && n == stall + 2) begin
        chk({name, "_hi_src1"}, {24'd0, bus.alu_src1}, {24'd0, b[15:8]});
        chk({name, "_hi_inv"}, {31'd0, bus.alu_src2_inv}, {31'd0, exp_inv});
        chk({name, "_hi_cin"}, {31'd0, bus.alu_c_in}, {31'd0, exp_cin});
        chk({name, "_hi_op"}, {29'd0, bus.alu_op}, {29'd0, ALUOP_ADD});
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      $display("FAIL %s_timeout: no done after %0d cycles", name, n);
      void'(sb.pop_front());
    end else begin
      passed++;
      got = sb.pop_front();
      chk({name, "_result"}, {16'd0, bus.result}, {16'd0, got.res});
      chk({name, "_page_cross"}, {31'd0, bus.page_cross}, {31'd0, got.pc});
      chk({name, "_latency"}, n, got.lat);
      chk({name, "_ready_in_done"}, {31'd0, bus.ready}, 32'd0);
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      chk({name, "_result_hold"}, {16'd0, bus.result}, {16'd0, got.res});
    end
  endtask

  task automatic test_reset();
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_page_cross", {31'd0, bus.page_cross}, 32'd0);
    chk("rst_alu_req", {31'd0, bus.alu_req}, 32'd0);
    chk("rst_alu_op", {29'd0, bus.alu_op}, {29'd0, ALUOP_HOLD});
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_index();
    run_op("idx_short", ASEQ_INDEX, 1'b0, 16'h12F0, 8'h05, 0);
    run_op("idx_cross", ASEQ_INDEX, 1'b0, 16'h12F0, 8'h20, 0);
    run_op("idx_wrap", ASEQ_INDEX, 1'b0, 16'hFFF0, 8'h20, 0);
  endtask

  task automatic test_branch();
    run_op("br_back", ASEQ_BRANCH, 1'b0, 16'h8002, 8'hFC, 0);
    run_op("br_back_nocross", ASEQ_BRANCH, 1'b0, 16'h80F0, 8'hF0, 0);
    run_op("br_fwd_cross", ASEQ_BRANCH, 1'b0, 16'h80F0, 8'h7F, 0);
  endtask

  task automatic test_force_hi();
    run_op("fh_cross", ASEQ_BRANCH, 1'b1, 16'h80F0, 8'h10, 0);
    run_op("fh_nocross", ASEQ_BRANCH, 1'b1, 16'h80F0, 8'h05, 0);
  endtask

  task automatic test_stall();
    run_op("stall_lo", ASEQ_INDEX, 1'b0, 16'h12F0, 8'h05, 3);
    run_op("stall_hi_path", ASEQ_INDEX, 1'b0, 16'h12F0, 8'h20, 2);
  endtask

  task automatic test_flush();
    logic [15:0] prev;
    logic        prev_pc;
    int          seen;
    wait_ready();
    prev = bus.result;
    @(negedge clk);
    bus.mode = ASEQ_INDEX; bus.force_hi = 1'b0; bus.base = 16'h12F0; bus.offset = 8'h20;
    bus.start = 1'b1; bus.alu_gnt = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("flush_in_hi_req", {31'd0, bus.alu_req}, 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_hi_ready", {31'd0, bus.ready}, 32'd1);
    chk("flush_hi_done", {31'd0, bus.done}, 32'd0);
    chk("flush_hi_result_hi", {24'd0, bus.result[15:8]}, {24'd0, prev[15:8]});
    prev    = bus.result;
    prev_pc = bus.page_cross;
    @(negedge clk);
    bus.base = 16'h4455; bus.offset = 8'hF0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    chk("flush_lo_no_done", seen, 0);
    chk("flush_lo_result", {16'd0, bus.result}, {16'd0, prev});
    chk("flush_lo_page_cross", {31'd0, bus.page_cross}, {31'd0, prev_pc});
  endtask

  task automatic test_reset_mid();
    wait_ready();
    @(negedge clk);
    bus.mode = ASEQ_INDEX; bus.force_hi = 1'b0; bus.base = 16'h12F0; bus.offset = 8'h20;
    bus.start = 1'b1; bus.alu_gnt = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rmid_in_lo", {31'd0, bus.alu_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid_ready", {31'd0, bus.ready}, 32'd1);
    chk("rmid_done", {31'd0, bus.done}, 32'd0);
    chk("rmid_result", {16'd0, bus.result}, 32'd0);
    chk("rmid_page_cross", {31'd0, bus.page_cross}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.alu_gnt = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_op("b2b", aseq_mode_t'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = ASEQ_INDEX; bus.force_hi = 1'b0;
    bus.base = 16'h0000; bus.offset = 8'h00; bus.flush = 1'b0; bus.alu_gnt = 1'b1;
    #1;
    test_reset();
    test_index();
    test_branch();
    test_force_hi();
    test_stall();
    test_flush();
    test_reset_mid();
    run_op("post_reset", ASEQ_BRANCH, 1'b0, 16'h0100, 8'h80, 0);
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
